// File: rtl/matacc_writer.sv
// Collects streamed A*B products into C elements, accumulating each over k
// through an external FP adder, and writes every finished element to a sink.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | accepting products for the current C element
//   WRITE | presenting the finished element until the sink takes it
//   FIN   | one-cycle done pulse
module matacc_writer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] num_i,
   input  logic [31:0] num_j,
   input  logic [31:0] num_k,
   input  logic        prod_valid,
   input  logic [31:0] prod_data,
   output logic        prod_ready,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_sum,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   input  logic        wr_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      WRITE = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ni_q, ni_d;
   logic [31:0] nj_q, nj_d;
   logic [31:0] nk_q, nk_d;
   logic [31:0] i_q, i_d;
   logic [31:0] j_q, j_d;
   logic [31:0] k_q, k_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] addr_q, addr_d;

   logic last_j;
   logic last_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ni_q    <= '0;
         nj_q    <= '0;
         nk_q    <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         ni_q    <= ni_d;
         nj_q    <= nj_d;
         nk_q    <= nk_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
      end
   end

   assign last_j = (j_q == nj_q - 32'd1);
   assign last_i = (i_q == ni_q - 32'd1);

   always_comb begin
      state_d = state_q;
      ni_d    = ni_q;
      nj_d    = nj_q;
      nk_d    = nk_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ni_d   = num_i;
               nj_d   = num_j;
               nk_d   = num_k;
               i_d    = '0;
               j_d    = '0;
               k_d    = '0;
               acc_d  = '0;
               addr_d = '0;
               if (num_i == '0 || num_j == '0 || num_k == '0)
                  state_d = FIN;
               else
                  state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (prod_valid) begin
               // first term of each element bypasses the adder so acc needs no clear
               acc_d = (k_q == '0) ? prod_data : add_sum;
               if (k_q == nk_q - 32'd1) begin
                  k_d     = '0;
                  state_d = WRITE;
               end else begin
                  k_d = k_q + 32'd1;
               end
            end
         end
         WRITE: begin
            if (wr_ready) begin
               addr_d = addr_q + 32'd1;
               if (last_j) begin
                  j_d = '0;
                  i_d = i_q + 32'd1;
               end else begin
                  j_d = j_q + 32'd1;
               end
               state_d = (last_i && last_j) ? FIN : ACCUM;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign prod_ready = (state_q == ACCUM);
   assign wr_en      = (state_q == WRITE);
   assign wr_addr    = addr_q;
   assign wr_data    = acc_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);
   assign add_a      = acc_q;
   assign add_b      = prod_data;

endmodule

// File: tb/tb_matacc_writer.sv
// Bench for matacc_writer: behavioural FP adder, per-matrix scoreboard of
// expected writes, handshake stalls, random valid gaps and mid-run reset.
module tb_matacc_writer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] num_i, num_j, num_k;
   logic        prod_valid;
   logic [31:0] prod_data;
   logic        prod_ready;
   logic [31:0] add_a, add_b, add_sum;
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic        wr_ready;
   logic        busy, done;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic [31:0] prods[$];

   matacc_writer dut (
      .clk(clk), .reset(reset), .start(start),
      .num_i(num_i), .num_j(num_j), .num_k(num_k),
      .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single <-> double conversion, exact for the small integer values used here
   function automatic real sp2r(input logic [31:0] b);
      logic [63:0] d;
      logic [10:0] e;
      if (b[30:0] == 31'd0) return 0.0;
      e = {3'b000, b[30:23]} + 11'd896;
      d = {b[31], e, b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   assign add_sum = r2sp(sp2r(add_a) + sp2r(add_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_mat(input int ni, input int nj, input int nk, input bit rand_valid,
                          input int stall, input bit spam, input logic [31:0] fixed);
      int          idx;
      int          stall_left;
      int          done_cnt;
      bit          fire_p;
      bit          finished;
      bit          degenerate;
      real         sum;
      logic [31:0] p;
      logic [63:0] e;
      prods.delete();
      exp_q.delete();
      degenerate = (ni == 0 || nj == 0 || nk == 0);
      if (!degenerate) begin
         for (int i = 0; i < ni; i++)
            for (int j = 0; j < nj; j++) begin
               sum = 0.0;
               for (int k = 0; k < nk; k++) begin
                  p = (fixed != 32'd0) ? fixed : r2sp(real'($urandom_range(1, 8)));
                  prods.push_back(p);
                  sum = (k == 0) ? sp2r(p) : sum + sp2r(p);
               end
               exp_q.push_back({32'(i * nj + j), r2sp(sum)});
            end
      end
      idx        = 0;
      stall_left = stall;
      done_cnt   = 0;
      finished   = 1'b0;
      @(negedge clk);
      num_i = 32'(ni); num_j = 32'(nj); num_k = 32'(nk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (degenerate) chk("degen_done_next", {31'd0, done}, 32'd1);
      else            chk("ready_after_start", {31'd0, prod_ready}, 32'd1);
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         prod_valid = (idx < prods.size()) && (!rand_valid || ($urandom_range(0, 2) != 0));
         prod_data  = (idx < prods.size()) ? prods[idx] : 32'd0;
         wr_ready   = 1'b1;
         start      = spam && busy && ($urandom_range(0, 1) == 1);
         if (wr_en && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
            chk("stall_addr", wr_addr, 32'd0);
            chk("stall_data", wr_data, exp_q.size() > 0 ? exp_q[0][31:0] : 32'hdead_beef);
            chk("stall_no_ready", {31'd0, prod_ready}, 32'd0);
         end
         if (degenerate) begin
            chk("degen_no_ready", {31'd0, prod_ready}, 32'd0);
            chk("degen_no_wr", {31'd0, wr_en}, 32'd0);
         end
         if (wr_en && wr_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", wr_addr, 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e[63:32]);
               chk("wr_data", wr_data, e[31:0]);
            end
         end
         fire_p = prod_valid && prod_ready;
         if (done) begin
            done_cnt++;
            finished = 1'b1;
         end
         @(negedge clk);
         if (fire_p) idx++;
      end
      start      = 1'b0;
      prod_valid = 1'b0;
      chk("finished", {31'd0, finished}, 32'd1);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_once", {31'd0, done}, 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("all_writes", 32'(exp_q.size()), 32'd0);
      chk("all_products", 32'(idx), 32'(prods.size()));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      num_i = '0; num_j = '0; num_k = '0;
      prod_valid = 1'b0; prod_data = '0; wr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_ready", {31'd0, prod_ready}, 32'd0);
      chk("rst_wr_addr", wr_addr, 32'd0);
      chk("rst_acc", add_a, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_mat(2, 2, 2, 1'b0, 0, 1'b0, 32'h3f80_0000);
      run_mat(1, 1, 1, 1'b0, 0, 1'b0, 32'h4040_0000);
      run_mat(2, 2, 0, 1'b0, 0, 1'b0, 32'd0);
      run_mat(2, 3, 2, 1'b0, 5, 1'b0, 32'd0);
      run_mat(3, 2, 4, 1'b1, 0, 1'b1, 32'd0);
      run_mat(1, 3, 1, 1'b1, 2, 1'b0, 32'd0);

      // reset during element 1 of a 2x2x2 matrix
      @(negedge clk);
      num_i = 32'd2; num_j = 32'd2; num_k = 32'd2;
      start = 1'b1;
      prod_valid = 1'b1; prod_data = 32'h3f80_0000; wr_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_state_accum", {31'd0, prod_ready}, 32'd1);
      chk("mid_addr", wr_addr, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("rst_now_busy", {31'd0, busy}, 32'd0);
      chk("rst_now_ready", {31'd0, prod_ready}, 32'd0);
      chk("rst_now_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_now_done", {31'd0, done}, 32'd0);
      chk("rst_now_addr", wr_addr, 32'd0);
      chk("rst_now_data", wr_data, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
         chk("post_rst_busy", {31'd0, busy}, 32'd0);
      end
      prod_valid = 1'b0;

      run_mat(1, 2, 3, 1'b0, 0, 1'b0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
